// File: rtl/dmi_req_arbiter_pkg.sv
// DMI request/response types shared with the debug transport, and sizing helpers for the arbiter.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;
  localparam logic [1:0] DTM_BUSY    = 2'h3;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

package dmi_req_arbiter_pkg;

  localparam int DmiReqW  = $bits(dm::dmi_req_t);
  localparam int DmiRespW = $bits(dm::dmi_resp_t);

  // Index/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dmi_rr_arb.sv
// Round-robin picker: first asserted request strictly after 'last', wrapping to 0.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when a pick is consumed and updates 'last'.
module dmi_rr_arb
  import dmi_req_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  localparam int         IdxW   = clog2_min1(int'(NumReq))
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   idx,
  output logic              found
);

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    // Upper segment above the last winner first, then wrap to the lower segment.
    for (int k = 0; k < int'(NumReq); k++) begin
      if (!found && req[k] && (k > int'(last))) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IdxW'(k);
      end
    end
    for (int k = 0; k < int'(NumReq); k++) begin
      if (!found && req[k] && (k <= int'(last))) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IdxW'(k);
      end
    end
  end

endmodule

// File: rtl/dmi_req_arbiter.sv
// Shares one DMI request/response channel among NumReq requesters, one transaction in flight, round-robin.
// Latency: accept->downstream valid 1 cycle; min accept-to-accept 4 cycles with a zero-wait downstream.
// Backpressure: valid/ready on every side; non-granted requesters see ready low until the transaction retires.
module dmi_req_arbiter
  import dm::*;
  import dmi_req_arbiter_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 256,
  localparam int         IdxW          = clog2_min1(int'(NumReq))
) (
  input  logic                             tck_i,
  input  logic                             trst_ni,
  input  logic                             clear_i,
  input  logic [NumReq-1:0]                req_valid_i,
  input  logic [NumReq-1:0][DmiReqW-1:0]   req_i,
  output logic [NumReq-1:0]                req_ready_o,
  output logic [NumReq-1:0]                resp_valid_o,
  output logic [DmiRespW-1:0]              resp_o,
  input  logic [NumReq-1:0]                resp_ready_i,
  output logic [DmiReqW-1:0]               dmi_req_o,
  output logic                             dmi_req_valid_o,
  input  logic                             dmi_req_ready_i,
  input  logic [DmiRespW-1:0]              dmi_resp_i,
  input  logic                             dmi_resp_valid_i,
  output logic                             dmi_resp_ready_o,
  output logic                             busy_o,
  output logic [IdxW-1:0]                  grant_o
);

  localparam int              TmrW    = clog2_min1(int'(TimeoutCycles) + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCycles - 1);
  localparam logic [IdxW-1:0] LastRst = IdxW'(NumReq - 1);

  typedef enum logic [2:0] {
    Idle     = 3'd0,
    Issue    = 3'd1,
    WaitResp = 3'd2,
    Respond  = 3'd3,
    Drain    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  dmi_req_t          req_buf_q, req_buf_d;
  dmi_resp_t         resp_q, resp_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic              drain_q, drain_d;
  logic [NumReq-1:0] resp_valid_q, resp_valid_d;
  logic              dmi_req_valid_q, dmi_req_valid_d;
  logic              busy_q, busy_d;

  logic [NumReq-1:0] arb_gnt;
  logic [IdxW-1:0]   arb_idx;
  logic              arb_found;

  dmi_rr_arb #(
    .NumReq (NumReq)
  ) u_rr_arb (
    .req   (req_valid_i),
    .last  (last_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  always_comb begin
    state_d          = state_q;
    req_buf_d        = req_buf_q;
    resp_d           = resp_q;
    last_d           = last_q;
    grant_d          = grant_q;
    timer_d          = timer_q;
    drain_d          = drain_q;
    req_ready_o      = '0;
    dmi_resp_ready_o = 1'b0;

    case (state_q)
      Idle: begin
        if (arb_found) begin
          req_ready_o = arb_gnt;
          req_buf_d   = dmi_req_t'(req_i[arb_idx]);
          last_d      = arb_idx;
          grant_d     = arb_idx;
          state_d     = Issue;
        end
      end
      Issue: begin
        if (dmi_req_ready_i) begin
          timer_d = '0;
          state_d = WaitResp;
        end
      end
      WaitResp: begin
        dmi_resp_ready_o = 1'b1;
        // A real response always beats the watchdog in the same cycle.
        if (dmi_resp_valid_i) begin
          resp_d  = dmi_resp_t'(dmi_resp_i);
          state_d = Respond;
        end else if ((TimeoutCycles != 0) && (timer_q == TmrLast)) begin
          resp_d  = '{data: 32'h0, resp: DTM_ERR};
          drain_d = 1'b1;
          state_d = Respond;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      Respond: begin
        if (resp_ready_i[grant_q]) begin
          state_d = drain_q ? Drain : Idle;
        end
      end
      Drain: begin
        dmi_resp_ready_o = 1'b1;
        if (dmi_resp_valid_i) begin
          drain_d = 1'b0;
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase

    if (clear_i) begin
      state_d          = Idle;
      req_buf_d        = '0;
      resp_d           = '0;
      last_d           = LastRst;
      grant_d          = '0;
      timer_d          = '0;
      drain_d          = 1'b0;
      req_ready_o      = '0;
      dmi_resp_ready_o = 1'b0;
    end

    // Valid/busy outputs are flopped from the next state so they never glitch.
    dmi_req_valid_d = (state_d == Issue);
    busy_d          = (state_d != Idle);
    resp_valid_d    = '0;
    if (state_d == Respond) resp_valid_d[grant_d] = 1'b1;
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q         <= Idle;
      req_buf_q       <= '0;
      resp_q          <= '0;
      last_q          <= LastRst;
      grant_q         <= '0;
      timer_q         <= '0;
      drain_q         <= 1'b0;
      resp_valid_q    <= '0;
      dmi_req_valid_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_buf_q       <= req_buf_d;
      resp_q          <= resp_d;
      last_q          <= last_d;
      grant_q         <= grant_d;
      timer_q         <= timer_d;
      drain_q         <= drain_d;
      resp_valid_q    <= resp_valid_d;
      dmi_req_valid_q <= dmi_req_valid_d;
      busy_q          <= busy_d;
    end
  end

  assign dmi_req_o       = req_buf_q;
  assign dmi_req_valid_o = dmi_req_valid_q;
  assign resp_o          = resp_q;
  assign resp_valid_o    = resp_valid_q;
  assign busy_o          = busy_q;
  assign grant_o         = grant_q;

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Directed bench for dmi_req_arbiter: round-robin, routing, stalls, watchdog/drain, clear and async reset.
module tb_dmi_req_arbiter;
  import dm::*;

  logic            tck = 1'b0;
  logic            trst_ni = 1'b0;
  logic            clear_i = 1'b0;
  logic [1:0]      req_valid_i = '0;
  logic [1:0][40:0] req_i;
  logic [1:0]      req_ready_o;
  logic [1:0]      resp_valid_o;
  logic [33:0]     resp_o;
  logic [1:0]      resp_ready_i = 2'b11;
  logic [40:0]     dmi_req_o;
  logic            dmi_req_valid_o;
  logic            dmi_req_ready_i = 1'b1;
  logic [33:0]     dmi_resp_i = '0;
  logic            dmi_resp_valid_i = 1'b0;
  logic            dmi_resp_ready_o;
  logic            busy_o;
  logic [0:0]      grant_o;

  int total = 0;
  int bad   = 0;

  always #5 tck = ~tck;

  dmi_req_arbiter #(
    .NumReq        (2),
    .TimeoutCycles (8)
  ) dut (
    .tck_i            (tck),
    .trst_ni          (trst_ni),
    .clear_i          (clear_i),
    .req_valid_i      (req_valid_i),
    .req_i            (req_i),
    .req_ready_o      (req_ready_o),
    .resp_valid_o     (resp_valid_o),
    .resp_o           (resp_o),
    .resp_ready_i     (resp_ready_i),
    .dmi_req_o        (dmi_req_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_resp_i       (dmi_resp_i),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .busy_o           (busy_o),
    .grant_o          (grant_o)
  );

  function automatic logic [40:0] mk_req(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
    return {a, op, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  // One zero-wait transaction; requester g must be the arbiter's pick this Idle cycle.
  task automatic txn(input int g, input logic [40:0] rq, input logic [33:0] rsp, input int dly);
    logic [1:0] oh;
    oh = 2'b01 << g;
    #1;
    chk("acc_ready", 64'(req_ready_o), 64'(oh));
    tick();
    chk("iss_grant", 64'(grant_o), 64'(g[0]));
    chk("iss_req", 64'({dmi_req_valid_o, dmi_req_o}), 64'({1'b1, rq}));
    chk("iss_noready", 64'(req_ready_o), 64'(0));
    tick();
    chk("wait_rdy", 64'(dmi_resp_ready_o), 64'(1));
    repeat (dly) tick();
    chk("wait_novalid", 64'(resp_valid_o), 64'(0));
    dmi_resp_i       = rsp;
    dmi_resp_valid_i = 1'b1;
    tick();
    dmi_resp_valid_i = 1'b0;
    chk("rsp_valid", 64'(resp_valid_o), 64'(oh));
    chk("rsp_data", 64'(resp_o), 64'(rsp));
    tick();
    chk("idle_busy", 64'(busy_o), 64'(0));
  endtask

  initial begin
    logic [40:0] r0, r1, rd11, wr22;
    logic [33:0] rsp5;
    r0   = mk_req(7'h05, DTM_READ, 32'h0);
    r1   = mk_req(7'h10, DTM_WRITE, 32'h1111_2222);
    rd11 = mk_req(7'h11, DTM_READ, 32'h0);
    wr22 = mk_req(7'h22, DTM_WRITE, 32'hDEAD_BEEF);
    rsp5 = {32'h5555_0000, DTM_SUCCESS};
    req_i[0] = r0;
    req_i[1] = r1;

    // Reset values
    repeat (3) tick();
    chk("rst_req_valid", 64'(dmi_req_valid_o), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid_o), 64'(0));
    chk("rst_resp", 64'(resp_o), 64'(0));
    chk("rst_dmi_req", 64'(dmi_req_o), 64'(0));
    chk("rst_busy_grant", 64'({busy_o, grant_o}), 64'(0));
    chk("rst_ready", 64'({req_ready_o, dmi_resp_ready_o}), 64'(0));
    trst_ni = 1'b1;
    tick();

    // Both requesters held: grants alternate 0,1,0,1
    req_valid_i = 2'b11;
    for (int k = 0; k < 4; k++)
      txn(k % 2, (k % 2 == 1) ? r1 : r0, {32'h1000_0000 + 32'(k), DTM_SUCCESS}, 0);

    // Read of 0x11 from requester 1, response after 5 cycles
    req_valid_i = 2'b10;
    req_i[1]    = rd11;
    txn(1, rd11, {32'hCAFE_0001, DTM_SUCCESS}, 5);

    // Downstream request stall for 20 cycles
    req_valid_i     = 2'b01;
    req_i[0]        = wr22;
    dmi_req_ready_i = 1'b0;
    #1;
    chk("stall_acc", 64'(req_ready_o), 64'(2'b01));
    tick();
    req_valid_i = 2'b00;
    for (int k = 0; k < 20; k++) begin
      chk("stall_hold", 64'({dmi_req_valid_o, dmi_req_o}), 64'({1'b1, wr22}));
      tick();
    end
    chk("stall_no_to", 64'({busy_o, resp_valid_o, dmi_resp_ready_o}), 64'(4'b1000));
    dmi_req_ready_i = 1'b1;
    tick();
    chk("stall_done", 64'(dmi_req_valid_o), 64'(0));
    dmi_resp_i       = {32'h5, DTM_SUCCESS};
    dmi_resp_valid_i = 1'b1;
    tick();
    dmi_resp_valid_i = 1'b0;
    chk("stall_rsp", 64'(resp_valid_o), 64'(2'b01));
    tick();

    // Watchdog: no response for 8 WaitResp cycles, then drain the late one
    req_i[0]    = r0;
    req_i[1]    = r1;
    req_valid_i = 2'b10;
    #1;
    chk("to_acc", 64'(req_ready_o), 64'(2'b10));
    tick();
    req_valid_i = 2'b00;
    tick();
    repeat (7) tick();
    chk("to_wait", 64'({resp_valid_o, dmi_resp_ready_o}), 64'(3'b001));
    tick();
    chk("to_valid", 64'(resp_valid_o), 64'(2'b10));
    chk("to_data", 64'(resp_o), 64'({32'h0, DTM_ERR}));
    tick();
    req_valid_i = 2'b01;
    #1;
    chk("drain_state", 64'({busy_o, dmi_resp_ready_o, req_ready_o, resp_valid_o}), 64'(6'b110000));
    dmi_resp_i       = {32'hBAD0_0BAD, DTM_SUCCESS};
    dmi_resp_valid_i = 1'b1;
    tick();
    dmi_resp_valid_i = 1'b0;
    chk("drain_swallow", 64'({resp_valid_o, resp_o}), 64'({2'b00, 32'h0, DTM_ERR}));
    txn(0, r0, {32'h0000_AAAA, DTM_SUCCESS}, 2);

    // Requester 0 holds off its response ready for 10 cycles
    resp_ready_i = 2'b10;
    #1;
    chk("hold_acc", 64'(req_ready_o), 64'(2'b01));
    tick();
    tick();
    dmi_resp_i       = rsp5;
    dmi_resp_valid_i = 1'b1;
    tick();
    dmi_resp_valid_i = 1'b0;
    req_valid_i      = 2'b11;
    for (int k = 0; k < 10; k++) begin
      chk("hold_rsp", 64'({resp_valid_o, resp_o, req_ready_o}), 64'({2'b01, rsp5, 2'b00}));
      tick();
    end
    resp_ready_i = 2'b11;
    tick();
    #1;
    chk("hold_next_rr", 64'(req_ready_o), 64'(2'b10));
    tick();
    chk("hold_next_grant", 64'(grant_o), 64'(1));
    tick();

    // Synchronous clear in WaitResp
    clear_i     = 1'b1;
    req_valid_i = 2'b00;
    tick();
    clear_i = 1'b0;
    chk("clr_a", 64'({resp_valid_o, dmi_req_valid_o, busy_o, grant_o, req_ready_o, dmi_resp_ready_o}), 64'(0));
    chk("clr_b", 64'({dmi_req_o, 2'b00}), 64'(0));
    chk("clr_c", 64'(resp_o), 64'(0));
    req_valid_i = 2'b11;
    #1;
    chk("clr_rr", 64'(req_ready_o), 64'(2'b01));
    tick();
    chk("clr_grant", 64'({grant_o, dmi_req_o}), 64'({1'b0, r0}));
    tick();
    dmi_resp_i       = rsp5;
    dmi_resp_valid_i = 1'b1;
    tick();
    dmi_resp_valid_i = 1'b0;
    tick();

    // Async reset while requester 1 sits in Issue
    dmi_req_ready_i = 1'b0;
    tick();
    chk("pre_rst", 64'({grant_o, dmi_req_valid_o, busy_o}), 64'(3'b111));
    req_valid_i = 2'b00;
    #2;
    trst_ni = 1'b0;
    #1;
    chk("arst_a", 64'({dmi_req_valid_o, busy_o, grant_o, resp_valid_o}), 64'(0));
    chk("arst_b", 64'(dmi_req_o), 64'(0));
    tick();
    tick();
    trst_ni         = 1'b1;
    dmi_req_ready_i = 1'b1;
    req_valid_i     = 2'b11;
    #1;
    chk("post_rst_rr", 64'(req_ready_o), 64'(2'b01));
    tick();
    chk("post_rst_grant", 64'({grant_o, dmi_req_o}), 64'({1'b0, r0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within 100000 time units");
    $fatal(1, "bench timeout");
  end

endmodule
